// File: rtl/handshake_4ph_rx.sv
// 4-phase bundled-data receiver: synchronises req, acks the sender,
// and buffers captured words in a FIFO drained as a valid/ready stream.
//
// Ports:
//   clk_i, rst_ni      clock (rising edge) and async active-low reset
//   req_i, data_i      async request and its bundled data word
//   ack_o              registered acknowledge back to the async stage
//   m_valid_o/m_data_o FIFO head stream, m_ready_i pops the head
//   level_o            FIFO occupancy
//   proto_err_o        sticky flag: req withdrawn before it was acked
module handshake_4ph_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_i,
  input  logic [DATA_W-1:0]        data_i,
  output logic                     ack_o,
  output logic                     m_valid_o,
  output logic [DATA_W-1:0]        m_data_o,
  input  logic                     m_ready_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     proto_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {
    IDLE,
    ACK
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic                   req_prev_q;
  logic                   ack_q;
  logic                   err_q;

  logic [DATA_W-1:0]      mem_q [DEPTH];
  logic [AW-1:0]          wr_q;
  logic [AW-1:0]          rd_q;
  logic [LW-1:0]          cnt_q;
  logic [LW-1:0]          cnt_d;

  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;

  assign req_s = sync_q[SYNC_STAGES-1];

  assign full  = (cnt_q == LW'(DEPTH));
  assign empty = (cnt_q == '0);

  // A held request while full is simply not acked
  // until a slot frees up.
  assign push = (state_q == IDLE) && req_s && !full;
  assign pop  = !empty && m_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q     <= '0;
      req_prev_q <= 1'b0;
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], req_i};
      req_prev_q <= req_s;
      unique case (state_q)
        IDLE: begin
          if (push) begin
            ack_q   <= 1'b1;
            state_q <= ACK;
          end else if (req_prev_q && !req_s) begin
            // req fell while still unacknowledged
            err_q <= 1'b1;
          end
        end
        ACK: begin
          if (!req_s) begin
            ack_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + LW'(1);
      2'b01:   cnt_d = cnt_q - LW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: contents are
  // only visible while the count says so.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= data_i;
  end

  assign ack_o       = ack_q;
  assign m_valid_o   = !empty;
  assign m_data_o    = mem_q[rd_q];
  assign level_o     = cnt_q;
  assign proto_err_o = err_q;

endmodule
